// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framer states, GMII transmit payload, CRC-32 constants and helpers.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        DRAIN
    } tx_state_e;

    typedef struct packed {
        logic [7:0] txd;
        logic       en;
        logic       er;
    } gmii_tx_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // One byte of reflected CRC-32, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

    // Register value after a frame and its FCS have both been folded in.
    function automatic logic crc32_residue_ok(input logic [31:0] crc);
        return crc == CRC32_RESIDUE;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Registered byte-wide IEEE 802.3 CRC-32 engine; init wins over en.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= CRC32_INIT;
        end else if (init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// Ethernet transmit framer: preamble/SFD, zero padding, FCS append, abort handling and inter-frame gap.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned MAX_FRAME    = 1514,
    parameter int unsigned IFG_LEN      = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun,
    output logic       oversize
);

    localparam int unsigned BCNT_W = $clog2(MAX_FRAME + 2);
    localparam int unsigned PH_MAX = (PREAMBLE_LEN > IFG_LEN) ? PREAMBLE_LEN : IFG_LEN;
    localparam int unsigned CNT_W  = $clog2(PH_MAX + 4);

    localparam logic [BCNT_W-1:0] MIN_CNT  = BCNT_W'(MIN_FRAME);
    localparam logic [BCNT_W-1:0] MAX_CNT  = BCNT_W'(MAX_FRAME);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    // The final gap cycle is spent in IDLE, so IFG itself lasts one cycle less.
    localparam logic [CNT_W-1:0]  IFG_LAST = CNT_W'(IFG_LEN - 2);
    localparam logic [CNT_W-1:0]  FCS_LAST = CNT_W'(3);

    tx_state_e         state_q, state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    gmii_tx_t          gmii_q, gmii_d;
    logic              done_d, underrun_d, oversize_d;

    logic              crc_init, crc_en;
    logic [7:0]        crc_data;
    logic [31:0]       crc;
    logic [31:0]       fcs;

    crc32_d8 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (crc_init),
        .en      (crc_en),
        .data    (crc_data),
        .crc     (crc)
    );

    assign fcs = ~crc;

    // State, counters and pin registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            cnt_q      <= '0;
            gmii_q     <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            oversize   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= cnt_d;
            gmii_q     <= gmii_d;
            frame_done <= done_d;
            underrun   <= underrun_d;
            oversize   <= oversize_d;
        end
    end

    // Next state and the values each state puts on the pins one cycle later.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        gmii_d     = '0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        oversize_d = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        crc_data   = in_data;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                crc_init   = 1'b1;
                byte_cnt_d = '0;
                cnt_d      = '0;
                if (in_valid) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                gmii_d = '{txd: ETH_PREAMBLE, en: 1'b1, er: 1'b0};
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = SFD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SFD: begin
                gmii_d  = '{txd: ETH_SFD, en: 1'b1, er: 1'b0};
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                if (!in_valid) begin
                    gmii_d     = '{txd: 8'h00, en: 1'b1, er: 1'b1};
                    underrun_d = 1'b1;
                    state_d    = DRAIN;
                end else if (byte_cnt_q == MAX_CNT) begin
                    // An oversize byte carrying in_last needs no draining.
                    gmii_d     = '{txd: 8'h00, en: 1'b1, er: 1'b1};
                    oversize_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = in_last ? IFG : DRAIN;
                end else begin
                    gmii_d     = '{txd: in_data, en: 1'b1, er: 1'b0};
                    crc_en     = 1'b1;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (in_last) begin
                        cnt_d   = '0;
                        state_d = (byte_cnt_d < MIN_CNT) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                gmii_d     = '{txd: 8'h00, en: 1'b1, er: 1'b0};
                crc_en     = 1'b1;
                crc_data   = 8'h00;
                byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                if (byte_cnt_q == MIN_CNT - BCNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = FCS;
                end
            end
            FCS: begin
                gmii_d = '{txd: fcs[{cnt_q[1:0], 3'b000} +: 8], en: 1'b1, er: 1'b0};
                if (cnt_q == FCS_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IFG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    cnt_d   = '0;
                    state_d = IFG;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign txd   = gmii_q.txd;
    assign tx_en = gmii_q.en;
    assign tx_er = gmii_q.er;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: per-cycle pin scoreboard plus per-frame length/pulse/CRC checks.
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] txd;
    logic       tx_en, tx_er, frame_done, underrun, oversize;

    always #4 clk = ~clk;

    gmii_tx_framer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .txd        (txd),
        .tx_en      (tx_en),
        .tx_er      (tx_er),
        .frame_done (frame_done),
        .underrun   (underrun),
        .oversize   (oversize)
    );

    typedef struct {
        logic [7:0] txd;
        logic       er;
        logic       done;
        logic       und;
        logic       ovs;
    } wire_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        int         drop;
        int         exp_on;
        int         exp_done;
        int         exp_und;
        int         exp_ovs;
    } vec_t;

    wire_t       exp_q[$];
    wire_t       mon_e;
    logic [7:0]  cap[$];
    logic [31:0] crc_tbl[256];
    vec_t        vecs[10];

    int n_cmp = 0;
    int n_err = 0;
    int on_cnt = 0, done_cnt = 0, und_cnt = 0, ovs_cnt = 0;
    int low_run = 0, last_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] idx;
        idx = c[7:0] ^ b;
        return crc_tbl[idx] ^ (c >> 8);
    endfunction

    // Expected pin sequence for one frame (stop>0: frame cut short by reset).
    task automatic push_expect(input int len, input logic [7:0] base, input int drop, input int stop);
        wire_t       w;
        logic [31:0] c;
        logic [31:0] f;
        logic [7:0]  b;
        int          k;
        logic        und, ovs;
        c = 32'hFFFFFFFF;
        k = len;
        und = 1'b0;
        ovs = 1'b0;
        if (stop > 0) k = stop;
        else if (drop > 0 && drop < len) begin k = drop; und = 1'b1; end
        else if (len > 1514) begin k = 1514; ovs = 1'b1; end
        for (int i = 0; i < 8; i++) begin
            w = '{txd: (i < 7) ? 8'h55 : 8'hD5, er: 1'b0, done: 1'b0, und: 1'b0, ovs: 1'b0};
            exp_q.push_back(w);
        end
        for (int i = 0; i < k; i++) begin
            b = 8'(base + i);
            w = '{txd: b, er: 1'b0, done: 1'b0, und: 1'b0, ovs: 1'b0};
            exp_q.push_back(w);
            c = crc_upd(c, b);
        end
        if (stop > 0) return;
        if (und || ovs) begin
            w = '{txd: 8'h00, er: 1'b1, done: 1'b0, und: und, ovs: ovs};
            exp_q.push_back(w);
            return;
        end
        for (int i = k; i < 60; i++) begin
            w = '{txd: 8'h00, er: 1'b0, done: 1'b0, und: 1'b0, ovs: 1'b0};
            exp_q.push_back(w);
            c = crc_upd(c, 8'h00);
        end
        f = ~c;
        for (int j = 0; j < 4; j++) begin
            w = '{txd: f[8*j +: 8], er: 1'b0, done: (j == 3), und: 1'b0, ovs: 1'b0};
            exp_q.push_back(w);
        end
    endtask

    // Drive a frame byte by byte; drop>0 inserts an in_valid gap, stop>0 quits early.
    task automatic send_bytes(input int len, input logic [7:0] base, input int drop, input int stop);
        int t;
        for (int i = 0; i < len; i++) begin
            if (stop > 0 && i == stop) break;
            if (drop > 0 && i == drop) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = 8'(base + i);
            in_last  = (i == len - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 300) break;
            end
            if (t > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready timeout: byte %0d never accepted", i);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || tx_en) && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 10000) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame end timeout: %0d expected bytes left", exp_q.size());
            exp_q.delete();
        end
        repeat (14) @(negedge clk);
    endtask

    task automatic clear_counts();
        on_cnt = 0;
        done_cnt = 0;
        und_cnt = 0;
        ovs_cnt = 0;
        cap.delete();
    endtask

    task automatic run_case(input vec_t v, input string tag, input bit gap_chk);
        logic [31:0] c;
        clear_counts();
        push_expect(v.len, v.base, v.drop, 0);
        send_bytes(v.len, v.base, v.drop, 0);
        wait_idle();
        chk({tag, " tx_en cycles"}, 32'(on_cnt), 32'(v.exp_on));
        chk({tag, " frame_done pulses"}, 32'(done_cnt), 32'(v.exp_done));
        chk({tag, " underrun pulses"}, 32'(und_cnt), 32'(v.exp_und));
        chk({tag, " oversize pulses"}, 32'(ovs_cnt), 32'(v.exp_ovs));
        if (v.exp_done == 1) begin
            c = 32'hFFFFFFFF;
            for (int i = 8; i < cap.size(); i++) c = crc_upd(c, cap[i]);
            chk({tag, " crc residue"}, c, 32'hDEBB20E3);
        end
        if (gap_chk) chk({tag, " gap>=12"}, 32'(last_gap >= 12), 32'd1);
    endtask

    // Pin monitor: every tx_en cycle is popped from the scoreboard, idle cycles must be all-zero.
    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_en) begin
                on_cnt++;
                cap.push_back(txd);
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
                if (exp_q.size() == 0) begin
                    chk("tx_en with nothing expected", 32'(tx_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("txd", 32'(txd), 32'(mon_e.txd));
                    chk("tx_er", 32'(tx_er), 32'(mon_e.er));
                    chk("frame_done", 32'(frame_done), 32'(mon_e.done));
                    chk("underrun", 32'(underrun), 32'(mon_e.und));
                    chk("oversize", 32'(oversize), 32'(mon_e.ovs));
                end
            end else begin
                low_run++;
                chk("idle pins", {20'h0, txd, tx_er, frame_done, underrun, oversize}, 32'h0);
            end
            done_cnt += 32'(frame_done);
            und_cnt  += 32'(underrun);
            ovs_cnt  += 32'(oversize);
        end
    end

    initial begin
        vec_t v;
        logic [31:0] c;

        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end

        //          len   base   drop exp_on done und ovs
        vecs[0] = '{60,   8'h00, 0,   72,    1,   0,  0};
        vecs[1] = '{14,   8'hA0, 0,   72,    1,   0,  0};
        vecs[2] = '{100,  8'h01, 20,  29,    0,   1,  0};
        vecs[3] = '{100,  8'h33, 0,   112,   1,   0,  0};
        vecs[4] = '{1600, 8'h00, 0,   1523,  0,   0,  1};
        vecs[5] = '{59,   8'h80, 0,   72,    1,   0,  0};
        vecs[6] = '{61,   8'hC0, 0,   73,    1,   0,  0};
        vecs[7] = '{1,    8'h5A, 0,   72,    1,   0,  0};
        vecs[8] = '{1514, 8'h07, 0,   1526,  1,   0,  0};
        vecs[9] = '{1515, 8'h0E, 0,   1523,  0,   0,  1};

        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset tx_en", 32'(tx_en), 32'd0);
        chk("reset txd", 32'(txd), 32'd0);
        chk("reset tx_er", 32'(tx_er), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset pulses", {29'h0, frame_done, underrun, oversize}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_case(vecs[i], $sformatf("vec%0d", i), i > 0);
        end

        // Back-to-back 64-byte frames with in_valid never dropping.
        clear_counts();
        push_expect(64, 8'h10, 0, 0);
        push_expect(64, 8'h90, 0, 0);
        send_bytes(64, 8'h10, 0, 0);
        send_bytes(64, 8'h90, 0, 0);
        wait_idle();
        chk("b2b tx_en cycles", 32'(on_cnt), 32'd152);
        chk("b2b frame_done pulses", 32'(done_cnt), 32'd2);
        chk("b2b gap", 32'(last_gap), 32'd12);

        // Reset asserted mid-frame between clock edges.
        clear_counts();
        push_expect(60, 8'h40, 0, 30);
        send_bytes(60, 8'h40, 0, 30);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset tx_en", 32'(tx_en), 32'd0);
        chk("async reset in_ready", 32'(in_ready), 32'd0);
        chk("async reset txd/tx_er", {23'h0, txd, tx_er}, 32'd0);
        chk("async reset pulses", {29'h0, frame_done, underrun, oversize}, 32'd0);
        chk("bytes before reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{60, 8'h22, 0, 72, 1, 0, 0};
        run_case(v, "post-reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
